// File: rtl/sync_ram_ctl.sv
// Single-clock synchronous RAM with request/acknowledge handshake, registered
// read data, out-of-range detection and a clear sequencer run after reset or on CLR.
`timescale 1ns/1ps

module sync_ram_ctl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              REQ,
    input  logic              WE,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic [DATA_W-1:0] WDATA,
    input  logic              CLR,
    output logic [DATA_W-1:0] RDATA,
    output logic              ACK,
    output logic              ERR,
    output logic              BUSY
);

    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH-1);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic [ADDR_W-1:0]   cnt_r;
    logic [ADDR_W-1:0]   cnt_s;
    logic [DATA_W-1:0]   rdata_r;
    logic [DATA_W-1:0]   rdata_s;
    logic                ack_r;
    logic                ack_s;
    logic                err_r;
    logic                err_s;
    logic                busy_r;
    logic                busy_s;
    logic                in_range_s;
    logic                mem_we_s;
    logic [ADDR_W-1:0]   mem_waddr_s;
    logic [DATA_W-1:0]   mem_wdata_s;
    logic [DATA_W-1:0]   mem_r [DEPTH];

    // Zero-extended compare; constant-true when DEPTH fills the address space.
    assign in_range_s = ({1'b0, ADDR} < DEPTH_EXT);

    // Next-state, single memory write port and registered-output next values.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        rdata_s     = rdata_r;
        ack_s       = 1'b0;
        err_s       = 1'b0;
        mem_we_s    = 1'b0;
        mem_waddr_s = cnt_r;
        mem_wdata_s = '0;
        case (state_r)
            ST_INIT: begin
                // CLR is deliberately not examined here: an ongoing clear never restarts.
                mem_we_s    = 1'b1;
                mem_waddr_s = cnt_r;
                mem_wdata_s = '0;
                if (cnt_r == LAST_ADDR) begin
                    state_s = ST_IDLE;
                    cnt_s   = '0;
                end else begin
                    cnt_s = cnt_r + ADDR_W'(1);
                end
            end
            ST_IDLE: begin
                if (CLR) begin
                    state_s = ST_INIT;
                    cnt_s   = '0;
                    rdata_s = '0;
                end else if (REQ) begin
                    ack_s = 1'b1;
                    err_s = ~in_range_s;
                    if (in_range_s && WE) begin
                        mem_we_s    = 1'b1;
                        mem_waddr_s = ADDR;
                        mem_wdata_s = WDATA;
                    end else if (in_range_s) begin
                        rdata_s = mem_r[ADDR];
                    end else begin
                        rdata_s = rdata_r;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            default: begin
                state_s = ST_INIT;
                cnt_s   = '0;
            end
        endcase
        busy_s = (state_s == ST_INIT);
    end

    // Control state and registered outputs.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r <= ST_INIT;
            cnt_r   <= '0;
            rdata_r <= '0;
            ack_r   <= 1'b0;
            err_r   <= 1'b0;
            busy_r  <= 1'b1;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            rdata_r <= rdata_s;
            ack_r   <= ack_s;
            err_r   <= err_s;
            busy_r  <= busy_s;
        end
    end

    // Storage array; not reset, the clear sequencer zeroes it instead.
    always_ff @(posedge CLK) begin
        if (mem_we_s) begin
            mem_r[mem_waddr_s] <= mem_wdata_s;
        end
    end

    assign RDATA = rdata_r;
    assign ACK   = ack_r;
    assign ERR   = err_r;
    assign BUSY  = busy_r;

endmodule

// File: tb/tb_sync_ram_ctl.sv
// Directed bench for sync_ram_ctl: a DEPTH=32 instance (a) and a DEPTH=24
// instance (b) sharing clock and reset, checked against hand-computed values.
`timescale 1ns/1ps

module tb_sync_ram_ctl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_a, we_a, clr_a, req_b, we_b, clr_b;
    logic [4:0] addr_a, addr_b;
    logic [7:0] wdata_a, wdata_b, rdata_a, rdata_b;
    logic       ack_a, err_a, busy_a, ack_b, err_b, busy_b;
    int         n_checks = 0;
    int         n_fail   = 0;

    always #5 clk = ~clk;

    sync_ram_ctl #(.DATA_W(8), .ADDR_W(5), .DEPTH(32)) dut_a (
        .CLK(clk), .RST_N(rst_n), .REQ(req_a), .WE(we_a), .ADDR(addr_a),
        .WDATA(wdata_a), .CLR(clr_a), .RDATA(rdata_a), .ACK(ack_a),
        .ERR(err_a), .BUSY(busy_a)
    );

    sync_ram_ctl #(.DATA_W(8), .ADDR_W(5), .DEPTH(24)) dut_b (
        .CLK(clk), .RST_N(rst_n), .REQ(req_b), .WE(we_b), .ADDR(addr_b),
        .WDATA(wdata_b), .CLR(clr_b), .RDATA(rdata_b), .ACK(ack_b),
        .ERR(err_b), .BUSY(busy_b)
    );

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One-cycle request on instance a (sel=0) or b (sel=1), then checks the response cycle
    // and that ACK drops again on the following cycle.
    task automatic access(input bit sel, input logic w, input logic [4:0] a, input logic [7:0] d,
                          input logic exp_err, input logic [7:0] exp_rd, input string tag);
        if (sel) begin
            req_b = 1'b1; we_b = w; addr_b = a; wdata_b = d;
        end else begin
            req_a = 1'b1; we_a = w; addr_a = a; wdata_a = d;
        end
        tick;
        req_a = 1'b0;
        req_b = 1'b0;
        check_value({tag, "_ack"},   sel ? ack_b : ack_a, 32'd1);
        check_value({tag, "_err"},   sel ? err_b : err_a, {31'd0, exp_err});
        check_value({tag, "_rdata"}, sel ? rdata_b : rdata_a, {24'd0, exp_rd});
        tick;
        check_value({tag, "_ackoff"}, sel ? ack_b : ack_a, 32'd0);
    endtask

    // Counts cycles until BUSY on instance a drops, bounded.
    task automatic count_busy(output int n);
        n = 0;
        while (busy_a && n < 100) begin
            tick;
            n++;
        end
    endtask

    initial begin
        int n;
        int n24;
        int acks;
        rst_n = 1'b0;
        req_a = 1'b0; we_a = 1'b0; clr_a = 1'b0; addr_a = 5'd0; wdata_a = 8'd0;
        req_b = 1'b0; we_b = 1'b0; clr_b = 1'b0; addr_b = 5'd0; wdata_b = 8'd0;
        tick;
        tick;
        check_value("rst_busy",  busy_a,  32'd1);
        check_value("rst_ack",   ack_a,   32'd0);
        check_value("rst_err",   err_a,   32'd0);
        check_value("rst_rdata", rdata_a, 32'd0);
        check_value("rst_busy_b", busy_b, 32'd1);

        // Clear after reset release: 32 cycles for a, 24 for b.
        rst_n = 1'b1;
        n   = 0;
        n24 = 0;
        while (busy_a && n < 100) begin
            if (busy_b) n24++;
            tick;
            n++;
        end
        check_value("init_len_32", n,   32'd32);
        check_value("init_len_24", n24, 32'd24);

        access(1'b0, 1'b0, 5'd0,  8'h00, 1'b0, 8'h00, "rd0");
        access(1'b0, 1'b0, 5'd15, 8'h00, 1'b0, 8'h00, "rd15");
        access(1'b0, 1'b0, 5'd31, 8'h00, 1'b0, 8'h00, "rd31");

        // Write then read-after-write with REQ held two cycles.
        req_a = 1'b1; we_a = 1'b1; addr_a = 5'd3; wdata_a = 8'hA5;
        tick;
        check_value("raw_wr_ack",   ack_a,   32'd1);
        check_value("raw_wr_rdata", rdata_a, 32'd0);
        we_a = 1'b0;
        tick;
        req_a = 1'b0;
        check_value("raw_rd_ack",   ack_a,   32'd1);
        check_value("raw_rd_err",   err_a,   32'd0);
        check_value("raw_rd_rdata", rdata_a, 32'hA5);
        tick;
        check_value("raw_ackoff",   ack_a,   32'd0);

        // Out-of-range handling on the DEPTH=24 instance.
        access(1'b1, 1'b1, 5'd23, 8'h5A, 1'b0, 8'h00, "b_wr23");
        access(1'b1, 1'b0, 5'd23, 8'h00, 1'b0, 8'h5A, "b_rd23");
        access(1'b1, 1'b0, 5'd24, 8'h00, 1'b1, 8'h5A, "b_rd24");
        access(1'b1, 1'b1, 5'd30, 8'hFF, 1'b1, 8'h5A, "b_wr30");
        access(1'b1, 1'b0, 5'd23, 8'h00, 1'b0, 8'h5A, "b_rd23b");

        // CLR wins over a simultaneous write request.
        access(1'b0, 1'b1, 5'd7, 8'h3C, 1'b0, 8'hA5, "wr7");
        access(1'b0, 1'b0, 5'd7, 8'h00, 1'b0, 8'h3C, "rd7");
        clr_a = 1'b1; req_a = 1'b1; we_a = 1'b1; addr_a = 5'd8; wdata_a = 8'h11;
        tick;
        clr_a = 1'b0; req_a = 1'b0;
        check_value("clr_ack",   ack_a,   32'd0);
        check_value("clr_busy",  busy_a,  32'd1);
        check_value("clr_rdata", rdata_a, 32'd0);
        count_busy(n);
        check_value("clr_len", n, 32'd32);
        access(1'b0, 1'b0, 5'd7, 8'h00, 1'b0, 8'h00, "clr_rd7");
        access(1'b0, 1'b0, 5'd8, 8'h00, 1'b0, 8'h00, "clr_rd8");

        // Reset in the middle of a clear restarts it from address 0.
        clr_a = 1'b1;
        tick;
        clr_a = 1'b0;
        for (int i = 0; i < 10; i++) tick;
        rst_n = 1'b0;
        #1;
        check_value("midrst_busy", busy_a, 32'd1);
        tick;
        rst_n = 1'b1;
        count_busy(n);
        check_value("midrst_len", n, 32'd32);

        // REQ held through reset and clear: one ACK on the first IDLE edge only.
        access(1'b0, 1'b1, 5'd5, 8'h66, 1'b0, 8'h00, "wr5");
        access(1'b0, 1'b0, 5'd5, 8'h00, 1'b0, 8'h66, "rd5");
        rst_n = 1'b0;
        req_a = 1'b1; we_a = 1'b0; addr_a = 5'd5;
        tick;
        check_value("hold_rst_rdata", rdata_a, 32'd0);
        rst_n = 1'b1;
        n    = 0;
        acks = 0;
        while (busy_a && n < 100) begin
            if (ack_a) acks++;
            tick;
            n++;
        end
        check_value("hold_len",       n,     32'd32);
        check_value("hold_busy_acks", acks,  32'd0);
        check_value("hold_ack_pre",   ack_a, 32'd0);
        tick;
        req_a = 1'b0;
        check_value("hold_ack",   ack_a,   32'd1);
        check_value("hold_err",   err_a,   32'd0);
        check_value("hold_rdata", rdata_a, 32'd0);
        tick;
        check_value("hold_ackoff", ack_a, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
